// File: rtl/des_sbox_engine.sv
// Time-multiplexed DES S-box stage: one 48-bit round value in, 32-bit S1..S8 result out,
// evaluating LANES boxes per cycle behind a valid/ready handshake.
module des_sbox_engine #(
  parameter int unsigned LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : gen_lanes_check
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  // Row-major FIPS 46-3 tables, index = row*16 + col.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [47:0] din_q, din_d;
  logic [31:0] res_q, res_d;
  logic        out_valid_q, busy_q;
  logic        last;
  logic [2:0]  box, rbox;
  logic [5:0]  chunk;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    din_d   = din_q;
    res_d   = res_q;
    box     = '0;
    rbox    = '0;
    chunk   = '0;
    // Widened so LANES=8 sees 0+8==8 rather than a 3-bit wrap.
    last    = ({1'b0, k_q} + 4'(LANES)) == 4'd8;

    if (clr) begin
      state_d = StIdle;
      k_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            din_d   = din;
            k_d     = '0;
            state_d = StBusy;
          end
        end
        StBusy: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            box   = k_q + 3'(l);
            rbox  = 3'd7 - box;
            chunk = din_q[rbox*6 +: 6];
            res_d[rbox*4 +: 4] = SBOX[box][{chunk[5], chunk[0], chunk[4:1]}];
          end
          k_d = k_q + 3'(LANES);
          if (last) begin
            k_d     = '0;
            state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      din_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      din_q       <= din_d;
      res_q       <= res_d;
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d == StBusy);
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dout      = res_q;

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed bench for des_sbox_engine: one instance per legal LANES value, shared clock,
// reset, clr, din and out_ready; each instance has its own in_valid.
module tb_des_sbox_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        out_ready;
  logic [47:0] din;
  logic        iv [4];
  logic        ir [4];
  logic        ov [4];
  logic        bz [4];
  logic [31:0] dq [4];

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;
  logic saw;

  always #5 clk = ~clk;

  des_sbox_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[0]), .in_ready(ir[0]), .din(din),
    .out_valid(ov[0]), .out_ready(out_ready), .dout(dq[0]), .busy(bz[0]));
  des_sbox_engine #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[1]), .in_ready(ir[1]), .din(din),
    .out_valid(ov[1]), .out_ready(out_ready), .dout(dq[1]), .busy(bz[1]));
  des_sbox_engine #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[2]), .in_ready(ir[2]), .din(din),
    .out_valid(ov[2]), .out_ready(out_ready), .dout(dq[2]), .busy(bz[2]));
  des_sbox_engine #(.LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[3]), .in_ready(ir[3]), .din(din),
    .out_valid(ov[3]), .out_ready(out_ready), .dout(dq[3]), .busy(bz[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Accept one job on instance idx, wait (bounded) for out_valid, check latency and result.
  task automatic run_job(input int idx, input logic [47:0] d, input logic [31:0] exp,
                         input int lat, input string tag);
    @(negedge clk);
    din     = d;
    iv[idx] = 1'b1;
    check({tag, "_in_ready"}, 32'(ir[idx]), 32'd1);
    @(negedge clk);
    iv[idx] = 1'b0;
    cnt = 0;
    while (!ov[idx] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(lat));
    check({tag, "_dout"}, dq[idx], exp);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_back_idle"}, 32'({ov[idx], ir[idx]}), 32'b01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    din = '0;
    for (int i = 0; i < 4; i++) iv[i] = 1'b0;
    #1;
    check("rst_in_ready", 32'(ir[1]), 32'd1);
    check("rst_out_valid", 32'(ov[1]), 32'd0);
    check("rst_busy", 32'(bz[1]), 32'd0);
    check("rst_dout", dq[1], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(1, 48'h0, 32'hEFA72C4D, 4, "zero_l2");
    run_job(0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 8, "ones_l1");
    run_job(1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 4, "ones_l2");
    run_job(2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 2, "ones_l4");
    run_job(3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 1, "ones_l8");
    run_job(1, 48'h000040000000, 32'hEFD72C4D, 4, "s3_row1");
    run_job(1, 48'h000001000000, 32'hEFAD2C4D, 4, "s4_row1");

    // Back-pressure on LANES=2.
    out_ready = 1'b0;
    @(negedge clk);
    din = 48'hFFFFFFFFFFFF;
    iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    check("bp_busy", 32'(bz[1]), 32'd1);
    cnt = 0;
    while (!ov[1] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_latency", 32'(cnt), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(ov[1]), 32'd1);
      check("bp_hold_dout", dq[1], 32'hD9CE3DCB);
      check("bp_hold_in_ready", 32'(ir[1]), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'({ov[1], ir[1]}), 32'b01);

    // clr on the second BUSY cycle at LANES=1.
    @(negedge clk);
    din = 48'hFFFFFFFFFFFF;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_state", 32'({ir[0], bz[0], ov[0]}), 32'b100);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[0]) saw = 1'b1;
    end
    check("clr_no_pulse", 32'(saw), 32'd0);
    run_job(0, 48'h0, 32'hEFA72C4D, 8, "after_clr");

    // clr beats in_valid in IDLE.
    @(negedge clk);
    din = 48'h0;
    iv[1] = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    clr = 1'b0;
    check("clr_vs_valid", 32'({ir[1], bz[1]}), 32'b10);

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    din = 48'h0;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy_flags", 32'({ir[0], bz[0], ov[0]}), 32'b100);
    check("rst_busy_dout", dq[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in DONE, with in_valid held through reset.
    out_ready = 1'b0;
    run_job(2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 2, "pre_rst_done");
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_flags", 32'({ir[2], bz[2], ov[2]}), 32'b100);
    check("rst_done_dout", dq[2], 32'h0);
    din = 48'h0;
    iv[1] = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    check("rst_release_accept", 32'({ir[1], bz[1]}), 32'b01);
    cnt = 0;
    while (!ov[1] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_release_latency", 32'(cnt), 32'd4);
    check("rst_release_dout", dq[1], 32'hEFA72C4D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
